// File: rtl/tx_prbs_rrc_polyphase.sv
// PRBS9 symbol source feeding a polyphase pulse-shaping FIR (x N_PHASES oversampling).
// Emits one saturated shaped sample per enabled clock plus the reference bit and symbol strobe.
module tx_prbs_rrc_polyphase #(
  parameter int NB_COEF    = 8,
  parameter int NB_OUTPUT  = 8,
  parameter int NBF_OUTPUT = 7,
  parameter int N_PHASES   = 4,
  parameter int NB_PHASE   = 2,
  parameter int N_TAPS     = 6,
  parameter int NB_FILL    = 3,
  parameter logic [8:0] SEED = 9'h1AA,
  parameter logic [N_TAPS*N_PHASES*NB_COEF-1:0] COEF =
    192'h010201FD_F8F6FC0C_243E525A_5A523E24_0CFCF6F8_FD010201
) (
  input  logic                        clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  output logic signed [NB_OUTPUT-1:0] o_sample,
  output logic                        o_prbs_bit,
  output logic                        o_symbol_strobe
);

  localparam int NB_ACC = NB_COEF + $clog2(N_TAPS);
  // Coefficients carry NB_COEF-1 fractional bits; align the sum to the output format.
  localparam int ALIGN_SHIFT = (NB_COEF - 1) - NBF_OUTPUT;
  localparam logic signed [NB_ACC-1:0] SAT_MAX = NB_ACC'(2 ** (NB_OUTPUT - 1) - 1);
  localparam logic signed [NB_ACC-1:0] SAT_MIN = ~SAT_MAX;

  logic [8:0]               lfsr_r;
  logic [NB_PHASE-1:0]      phase_r;
  logic [N_TAPS-1:0]        sym_r;
  logic [NB_FILL-1:0]       fill_r;
  logic                     new_bit_s;
  logic                     sym_wrap_s;
  logic signed [NB_ACC-1:0] acc_s;
  logic signed [NB_ACC-1:0] acc_aligned_s;

  function automatic logic signed [NB_OUTPUT-1:0] saturate(input logic signed [NB_ACC-1:0] v);
    if (v > SAT_MAX) begin
      return {1'b0, {(NB_OUTPUT-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      return {1'b1, {(NB_OUTPUT-1){1'b0}}};
    end else begin
      return v[NB_OUTPUT-1:0];
    end
  endfunction

  assign new_bit_s  = lfsr_r[8] ^ lfsr_r[4];
  assign sym_wrap_s = (phase_r == NB_PHASE'(N_PHASES - 1));

  // Branch sum for the current phase; taps not yet filled since reset contribute nothing.
  always_comb begin
    acc_s = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      if (NB_FILL'(k) < fill_r) begin
        if (sym_r[k]) begin
          acc_s = acc_s + NB_ACC'($signed(COEF[(k*N_PHASES + int'(phase_r))*NB_COEF +: NB_COEF]));
        end else begin
          acc_s = acc_s - NB_ACC'($signed(COEF[(k*N_PHASES + int'(phase_r))*NB_COEF +: NB_COEF]));
        end
      end else begin
        acc_s = acc_s;
      end
    end
    acc_aligned_s = acc_s >>> ALIGN_SHIFT;
  end

  // Symbol clocking, phase rotation and registered outputs.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      lfsr_r          <= SEED;
      phase_r         <= '0;
      sym_r           <= '0;
      fill_r          <= '0;
      o_sample        <= '0;
      o_prbs_bit      <= 1'b0;
      o_symbol_strobe <= 1'b0;
    end else if (i_enable) begin
      phase_r  <= sym_wrap_s ? '0 : phase_r + NB_PHASE'(1);
      o_sample <= saturate(acc_aligned_s);
      o_symbol_strobe <= (phase_r == '0);
      if (phase_r == '0) begin
        o_prbs_bit <= sym_r[0];
      end else begin
        o_prbs_bit <= o_prbs_bit;
      end
      if (sym_wrap_s) begin
        lfsr_r <= {lfsr_r[7:0], new_bit_s};
        sym_r  <= {sym_r[N_TAPS-2:0], new_bit_s};
        if (fill_r != NB_FILL'(N_TAPS)) begin
          fill_r <= fill_r + NB_FILL'(1);
        end else begin
          fill_r <= fill_r;
        end
      end else begin
        lfsr_r <= lfsr_r;
        sym_r  <= sym_r;
        fill_r <= fill_r;
      end
    end else begin
      o_symbol_strobe <= 1'b0;
    end
  end

endmodule
